// File: rtl/team_06_pkg.sv
// Shared constants and types for the team_06 audio path.
// Slot geometry, default sample width and the sample type.
package team_06_pkg;

  localparam int I2S_SLOTS    = 32;
  localparam int SLOT_W       = $clog2(I2S_SLOTS);
  localparam int SAMPLE_W_DEF = 16;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  // Slot lies in the captured window 1..last (slot 0 is the delay bit).
  function automatic logic in_window(
    input logic [SLOT_W-1:0] slot,
    input logic [SLOT_W-1:0] last
  );
    return (slot != '0) && (slot <= last);
  endfunction

endpackage

// File: rtl/team_06_i2s_clkgen.sv
// I2S master clock generator: bit clock, word select, slot counter.
// Ports: hwclk_i, clr_i (sync clear) -> i2sclk_o, ws_o, bit_cnt_o, rise_o, fall_o, half_end_o.
module team_06_i2s_clkgen
  import team_06_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              hwclk_i,
  input  logic              clr_i,
  output logic              i2sclk_o,
  output logic              ws_o,
  output logic [SLOT_W-1:0] bit_cnt_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic              half_end_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(I2S_SLOTS - 1);

  logic [DW-1:0]     div_q, div_d;
  logic              clk_q, clk_d;
  logic              ws_q, ws_d;
  logic [SLOT_W-1:0] bit_q, bit_d;
  logic              tick;

  assign tick       = (div_q == DIV_MAX);
  assign rise_o     = tick & ~clk_q;
  assign fall_o     = tick & clk_q;
  assign half_end_o = fall_o & (bit_q == SLOT_MAX);

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    clk_d = clk_q ^ tick;
    bit_d = fall_o ? bit_q + SLOT_W'(1) : bit_q;
    ws_d  = ws_q ^ half_end_o;
  end

  always_ff @(posedge hwclk_i) begin
    if (clr_i) begin
      div_q <= '0;
      clk_q <= 1'b0;
      ws_q  <= 1'b0;
      bit_q <= '0;
    end else begin
      div_q <= div_d;
      clk_q <= clk_d;
      ws_q  <= ws_d;
      bit_q <= bit_d;
    end
  end

  assign i2sclk_o  = clk_q;
  assign ws_o      = ws_q;
  assign bit_cnt_o = bit_q;

endmodule

// File: rtl/team_06_adc_i2s_rx.sv
// I2S master receiver: left-channel capture into a 1-deep valid/ready register.
// Ports: hwclk, reset, en, adc_serial_in, sample_ready -> i2sclk, wsADC, sample_out, sample_valid, overrun.
module team_06_adc_i2s_rx
  import team_06_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                hwclk,
  input  logic                reset,
  input  logic                en,
  input  logic                adc_serial_in,
  output logic                i2sclk,
  output logic                wsADC,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SAMPLE_W);

  logic              clr;
  logic              rise, fall, half_end;
  logic [SLOT_W-1:0] bit_cnt;
  logic              cap;

  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] samp_q, samp_d;
  logic                prime_q, prime_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  assign clr = reset | ~en;

  team_06_i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .hwclk_i    (hwclk),
    .clr_i      (clr),
    .i2sclk_o   (i2sclk),
    .ws_o       (wsADC),
    .bit_cnt_o  (bit_cnt),
    .rise_o     (rise),
    .fall_o     (fall),
    .half_end_o (half_end)
  );

  assign cap = rise & ~wsADC & in_window(bit_cnt, LAST);

  always_comb begin
    shift_d = shift_q;
    prime_d = prime_q;
    samp_d  = samp_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (cap) begin
      shift_d = (shift_q << 1) | SAMPLE_W'(adc_serial_in);
    end else if (half_end & wsADC) begin
      shift_d = '0;
    end
    // The first left half after start has no real WS edge before it.
    if (half_end & ~wsADC) begin
      prime_d = 1'b1;
    end
    done_d = cap & prime_q & (bit_cnt == LAST);
    if (done_q) begin
      samp_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q & ~sample_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q & sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge hwclk) begin
    if (clr) begin
      shift_q <= '0;
      prime_q <= 1'b0;
      done_q  <= 1'b0;
      samp_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      prime_q <= prime_d;
      done_q  <= done_d;
      samp_q  <= samp_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_out   = samp_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_team_06_adc_i2s_rx.sv
// Directed bench for team_06_adc_i2s_rx with an ADC model and scoreboard.
// Timing is counted in hwclk edges since reset release / enable.
module tb_team_06_adc_i2s_rx;

  logic        hwclk = 1'b0;
  logic        reset;
  logic        en;
  logic        adc;
  logic        ready;
  logic        i2sclk;
  logic        ws;
  logic [15:0] sout;
  logic        valid;
  logic        ovr;

  int checks = 0;
  int errors = 0;
  int n;
  int fbase;
  int first_v;

  logic [15:0] fw [0:11];
  logic [15:0] sbq [$];

  always #5 hwclk = ~hwclk;

  team_06_adc_i2s_rx #(
    .CLK_DIV  (4),
    .SAMPLE_W (16)
  ) dut (
    .hwclk         (hwclk),
    .reset         (reset),
    .en            (en),
    .adc_serial_in (adc),
    .i2sclk        (i2sclk),
    .wsADC         (ws),
    .sample_out    (sout),
    .sample_valid  (valid),
    .sample_ready  (ready),
    .overrun       (ovr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model: slot k occupies edges 8k..8k+7, rising i2sclk at 8k+4.
  task automatic drive();
    int s;
    int fi;
    logic [15:0] w;
    s  = (n / 8) % 64;
    fi = fbase + n / 512;
    w  = fw[fi];
    if (s >= 1 && s <= 16) adc = w[16 - s];
    else adc = 1'($urandom_range(0, 1));
    if (s == 16 && n % 8 == 0 && n >= 512) sbq.push_back(w);
  endtask

  task automatic step();
    logic        xfer;
    logic [15:0] d;
    logic [15:0] e;
    xfer = valid && ready;
    d    = sout;
    @(posedge hwclk);
    #1;
    n++;
    if (xfer) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL xfer_unexpected observed=%0h expected=none", d);
      end else begin
        e = sbq.pop_front();
        chk("xfer_data", {16'h0, d}, {16'h0, e});
      end
    end
    if (valid && first_v == 0) first_v = n;
    drive();
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_i2sclk"}, {31'h0, i2sclk}, 32'h0);
    chk({tag, "_ws"}, {31'h0, ws}, 32'h0);
    chk({tag, "_sample"}, {16'h0, sout}, 32'h0);
    chk({tag, "_valid"}, {31'h0, valid}, 32'h0);
    chk({tag, "_ovr"}, {31'h0, ovr}, 32'h0);
  endtask

  initial begin
    fw[0]  = 16'hDEAD; fw[1]  = 16'hA5C3;
    fw[2]  = 16'hA5C3; fw[3]  = 16'h8001;
    fw[4]  = 16'h7FFF; fw[5]  = 16'h5A5A;
    fw[6]  = 16'h3C3C; fw[7]  = 16'h1111;
    fw[8]  = 16'h2222; fw[9]  = 16'h9999;
    fw[10] = 16'hBEEF; fw[11] = 16'h0F0F;
    reset = 1'b1; en = 1'b1; ready = 1'b1; adc = 1'b0;
    n = 0; fbase = 0; first_v = 0;
    repeat (3) @(posedge hwclk);
    #1;
    chk_idle("rst");
    reset = 1'b0;
    drive();

    run_to(3);   chk("clk_e3", {31'h0, i2sclk}, 32'h0);
    run_to(4);   chk("clk_e4", {31'h0, i2sclk}, 32'h1);
    run_to(8);   chk("clk_e8", {31'h0, i2sclk}, 32'h0);
    run_to(255); chk("ws_e255", {31'h0, ws}, 32'h0);
    run_to(256); chk("ws_e256", {31'h0, ws}, 32'h1);
    run_to(512); chk("no_valid_f0", first_v, 0);
    run_to(644); chk("valid_e644", {31'h0, valid}, 32'h0);
    run_to(645); chk("valid_e645", {31'h0, valid}, 32'h1);
    chk("data_e645", {16'h0, sout}, 32'hA5C3);
    run_to(646); chk("pulse_e646", {31'h0, valid}, 32'h0);
    chk("first_v", first_v, 645);
    run_to(1156); chk("valid_e1156", {31'h0, valid}, 32'h0);
    run_to(1157); chk("valid_e1157", {31'h0, valid}, 32'h1);

    run_to(2600);
    chk("sb_sign", sbq.size(), 0);
    ready = 1'b0;
    run_to(3204);
    chk("hold_data", {16'h0, sout}, 32'h5A5A);
    ready = 1'b1;
    run_to(3205);
    chk("sim_valid", {31'h0, valid}, 32'h1);
    chk("sim_data", {16'h0, sout}, 32'h3C3C);
    chk("sim_ovr", {31'h0, ovr}, 32'h0);
    run_to(3206);
    chk("sim_drain", {31'h0, valid}, 32'h0);

    run_to(3600);
    ready = 1'b0;
    run_to(4228);
    chk("bp_valid1", {31'h0, valid}, 32'h1);
    chk("bp_data1", {16'h0, sout}, 32'h1111);
    chk("bp_ovr0", {31'h0, ovr}, 32'h0);
    run_to(4229);
    sbq.delete(0);
    chk("bp_valid2", {31'h0, valid}, 32'h1);
    chk("bp_data2", {16'h0, sout}, 32'h2222);
    chk("bp_ovr1", {31'h0, ovr}, 32'h1);
    run_to(4300);
    ready = 1'b1;
    run_to(4302);
    chk("bp_drain", {31'h0, valid}, 32'h0);
    chk("bp_sticky", {31'h0, ovr}, 32'h1);

    run_to(4676);
    en = 1'b0;
    run_to(4677);
    chk_idle("endrop");
    run_to(4680);
    chk("sb_drop", sbq.size(), 0);
    en = 1'b1; n = 0; fbase = 10; first_v = 0;
    drive();
    run_to(4);   chk("re_clk_e4", {31'h0, i2sclk}, 32'h1);
    run_to(644); chk("re_valid_e644", {31'h0, valid}, 32'h0);
    run_to(645); chk("re_valid_e645", {31'h0, valid}, 32'h1);
    chk("re_data", {16'h0, sout}, 32'h0F0F);
    run_to(700);
    chk("re_first_v", first_v, 645);
    chk("sb_end", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/team_06_adc_i2s_rx.md
Name: team_06_adc_i2s_rx

Overview:
I2S master receiver for the audio ADC. It sits directly upstream of the audio effect/noise-gate path inside team_06_top.
- Generates the ADC bit clock and word select.
- Deserialises the left-channel sample from the ADC serial pin.
- Presents each sample on a 1-deep valid/ready output register to the downstream processing stage.

Parameters:
- CLK_DIV, 4: hwclk cycles per half period of i2sclk (i2sclk period = 2*CLK_DIV hwclk cycles); legal range >= 2.
- SAMPLE_W, 16: captured sample width in bits, MSB first; legal range 1..31.

Ports:
- hwclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- en  in  1  receiver enable; low forces the idle/reset state next cycle.
- adc_serial_in  in  1  ADC serial data, sampled on i2sclk rising edges.
- i2sclk  out  1  bit clock to ADC (registered).
- wsADC  out  1  word select to ADC; 0 = left channel, 1 = right channel (registered).
- sample_out  out  SAMPLE_W  last captured left sample, two's complement as received.
- sample_valid  out  1  sample_out holds an unconsumed sample.
- sample_ready  in  1  downstream accepts; transfer occurs when valid && ready.
- overrun  out  1  sticky: a sample was overwritten before it was accepted.

Behaviour:
- Reset / en low (synchronous, same effect):
  - div_cnt=0, bit_cnt=0, i2sclk=0, wsADC=0, shift reg=0, prime=0.
  - sample_out=0, sample_valid=0, overrun=0.
  - en deassertion mid-frame discards any partial sample; no valid pulse is produced.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - When div_cnt==CLK_DIV-1, i2sclk toggles on that edge.
  - Resulting edge timing: rise_evt (0->1) and fall_evt (1->0).
- Bit counter:
  - On fall_evt, bit_cnt increments modulo 32.
  - When bit_cnt wraps 31->0, wsADC toggles and the frame half changes.
  - One full frame = 64 bit clocks = 128*CLK_DIV hwclk cycles.
- Capture (standard I2S, 1-bit delay):
  - On rise_evt with wsADC==0 and 1 <= bit_cnt <= SAMPLE_W, shift adc_serial_in into the LSB of the shift register.
  - Slots 0 and SAMPLE_W+1..31 are ignored, as is the whole right half.
- Completion:
  - The capture at bit_cnt==SAMPLE_W completes a word.
  - On the next hwclk edge the word is loaded into sample_out and sample_valid is set (latency 1 cycle from the LSB capture edge).
  - The shift register clears when the next left half starts.
- Prime:
  - The first left half after reset/enable does not begin on a real WS transition, so it is discarded.
  - prime is set at the end of that half; words complete only when prime==1.
- Handshake:
  - valid && ready clears sample_valid on the next edge.
  - A new word completing on the same edge as an accept leaves valid=1 with the new data and no overrun.
  - A new word completing while valid=1 and ready=0 overwrites sample_out, keeps valid=1, and sets overrun.
  - overrun clears only on reset or en low.
- wsADC/i2sclk registered: no combinational path from any input to any output.
- Timing reference (CLK_DIV=4, SAMPLE_W=16; hwclk edges numbered from 1 after reset release, en=1):
  - i2sclk rises at edge 8k+4 and falls at edge 8k+8 (k = absolute slot).
  - First wsADC toggle at edge 256.
  - First sample_valid high after edge 645 (slot 80 LSB capture at edge 644).

Decomposition:
- team_06_pkg:
  - localparam I2S_SLOTS=32 (bit clocks per channel).
  - Default SAMPLE_W constant.
  - typedef sample_t = logic signed [SAMPLE_W-1:0], shared with the effect/DAC stages.
- Sub-module team_06_i2s_clkgen (div_cnt, i2sclk, wsADC, bit_cnt, rise_evt/fall_evt strobes). It is reused by the DAC transmitter for i2sclk_out_chip/word_select.

Test Plan:
- Startup timing (CLK_DIV=4): reset then en=1 -> i2sclk first rises at edge 4, wsADC first toggles at edge 256, and there is no valid during the first frame.
- Capture: ADC model drives 16'hA5C3 MSB-first into left slots 1..16 of every frame, with garbage in the right half and slots 0/17..31, and ready=1 -> sample_out=16'hA5C3 with a 1-cycle valid pulse first after edge 645, then every 512 cycles.
- Sign/width: drive 16'h8001 then 16'h7FFF -> sample_out exactly 16'h8001, then 16'h7FFF, with no bit slip.
- Backpressure: ready=0 across two frames carrying 16'h1111 then 16'h2222 -> valid stays 1, sample_out=16'h2222, overrun=1 and sticky after ready returns to 1.
- Simultaneous: ready asserted exactly on the edge the next word completes -> valid remains 1 with new data and overrun stays 0.
- Enable drop: en=0 at left slot 8 -> all outputs return to reset values next cycle. On re-enable, the first half is discarded and the first valid appears 645 cycles after en rises.
